// File: rtl/out_port_sched.sv
// out_port_sched: posted-write FIFO and pacer in front of the 4-port output bank.
// CPU writes {port, data} are queued. They are drained in order as single-cycle
// out_we pulses, and each pulse is followed by HOLD forced idle cycles.
// Optional build macro OUT_SCHED_OVF_EN adds a sticky overflow flag (ovf) with
// a clear input (ovf_clr). This flag records writes dropped because the FIFO was full.
module out_port_sched #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [1:0]               wr_port,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_full,
    output logic                     out_we,
    output logic [1:0]               out_sel,
    output logic [WIDTH-1:0]         out_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef OUT_SCHED_OVF_EN
    ,
    input  logic                     ovf_clr,
    output logic                     ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [LW-1:0]        level_next;
    logic [WIDTH+1:0]     mem [DEPTH];
    logic                 push;
    logic                 pop;

    // Accept only against the registered full flag, so a same-cycle pop never frees a slot
    assign push = wr_req && !wr_full;
    assign pop  = (state == IDLE) && (level != '0);

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Pacer: issue from IDLE, then count HOLD idle cycles in GAP before issuing again
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = GAP;
                    cnt_next   = CW'(HOLD);
                end
            end
            GAP: begin
                if (cnt <= CW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {wr_port, wr_data};
        end
    end

    // Pointers, occupancy and pacer state; reset drops queued entries at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            level <= level_next;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered outputs; sel/data keep the last issued entry between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_we   <= 1'b0;
            out_sel  <= '0;
            out_data <= '0;
            wr_full  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            out_we  <= pop;
            if (pop) begin
                out_sel  <= mem[head][WIDTH+1:WIDTH];
                out_data <= mem[head][WIDTH-1:0];
            end
            wr_full <= (level_next == LW'(DEPTH));
            busy    <= (level_next != '0) || (state_next != IDLE);
        end
    end

`ifdef OUT_SCHED_OVF_EN
    // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wr_req && wr_full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_out_port_sched.sv
// Bench for out_port_sched: directed scenarios plus random traffic.
// Expected pulses are queued by the driver and retired by a negedge monitor.
module tb_out_port_sched;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    typedef struct packed {
        logic [1:0]       p;
        logic [WIDTH-1:0] d;
    } item_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_req = 1'b0;
    logic [1:0]       wr_port = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_full;
    logic             out_we;
    logic [1:0]       out_sel;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic [$clog2(DEPTH):0] level;
`ifdef OUT_SCHED_OVF_EN
    logic             ovf_clr = 1'b0;
    logic             ovf;
`endif

    out_port_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_port  (wr_port),
        .wr_data  (wr_data),
        .wr_full  (wr_full),
        .out_we   (out_we),
        .out_sel  (out_sel),
        .out_data (out_data),
        .busy     (busy),
        .level    (level)
`ifdef OUT_SCHED_OVF_EN
        ,
        .ovf_clr  (ovf_clr),
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    bit    in_reset = 1'b1;

    // Reference model: a queue of accepted writes and a cooldown in cycles
    item_t mq[$];
    item_t sb[$];
    int    cd = 0;
    bit    exp_we = 1'b0;
    item_t last = '0;
    bit    exp_ovf = 1'b0;
    item_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        cd      = 0;
        exp_we  = 1'b0;
        last    = '0;
        exp_ovf = 1'b0;
    endtask

    // One rising edge of the specified behaviour, evaluated on pre-edge state
    task automatic model_edge(input bit req, input item_t it, input bit clr);
        bit full;
        bit pop;
        full = (mq.size() == DEPTH);
        pop  = (cd == 0) && (mq.size() > 0);
        if (pop) begin
            last   = mq.pop_front();
            exp_we = 1'b1;
            cd     = HOLD;
        end else begin
            exp_we = 1'b0;
            if (cd > 0) cd--;
        end
        if (req && !full) begin
            mq.push_back(it);
            sb.push_back(it);
        end
        if (req && full) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
    endtask

    task automatic cycle(input bit req, input logic [1:0] p, input logic [WIDTH-1:0] d,
                         input bit clr);
        item_t it;
        wr_req  = req;
        wr_port = p;
        wr_data = d;
`ifdef OUT_SCHED_OVF_EN
        ovf_clr = clr;
`endif
        it.p = p;
        it.d = d;
        @(posedge clk);
        model_edge(req, it, clr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_we"}, out_we, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wr_full"}, wr_full, 0);
        check({tag, "_out_sel"}, out_sel, 0);
        check({tag, "_out_data"}, out_data, 0);
`ifdef OUT_SCHED_OVF_EN
        check({tag, "_ovf"}, ovf, 0);
`endif
    endtask

    // Monitor: compare every cycle, retiring a scoreboard entry on each pulse
    always @(negedge clk) begin
        if (!in_reset) begin
            check("out_we", out_we, exp_we);
            if (out_we === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: got out_we=1 expected no pending write at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_sel", out_sel, mon_e.p);
                    check("out_data", out_data, mon_e.d);
                end
            end else begin
                check("held_sel", out_sel, last.p);
                check("held_data", out_data, last.d);
            end
            check("level", level, mq.size());
            check("wr_full", wr_full, mq.size() == DEPTH);
            check("busy", busy, (mq.size() > 0) || (cd > 0));
`ifdef OUT_SCHED_OVF_EN
            check("ovf", ovf, exp_ovf);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        #1 reset = 1'b0;
        #1 check_zero_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 in_reset = 1'b0;

        // Single write, port 2 / 0x5A
        cycle(1'b1, 2'd2, 8'h5A, 1'b0);
        idle(6);

        // Four back-to-back writes
        cycle(1'b1, 2'd0, 8'h11, 1'b0);
        cycle(1'b1, 2'd1, 8'h22, 1'b0);
        cycle(1'b1, 2'd3, 8'h33, 1'b0);
        cycle(1'b1, 2'd0, 8'h44, 1'b0);
        idle(15);

        // Saturate: fill, drop, full-with-pop, then clear the overflow flag
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'(i), 8'hA0 + 8'(i), 1'b0);
        idle(2);
        cycle(1'b0, 2'd0, '0, 1'b1);
        idle(25);

        // Reset mid-GAP with three entries queued
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'(3 - i), 8'hC0 + 8'(i), 1'b0);
        #2 in_reset = 1'b1;
        reset = 1'b0;
        wr_req = 1'b0;
        #1 check_zero_outputs("midrst");
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 in_reset = 1'b0;
        idle(6);

        // Ten writes interleaved with drains across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'(i), 8'h60 + 8'(i), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(20);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 3) != 0, 2'($urandom), 8'($urandom), ($urandom % 8) == 0);
        end
        idle(30);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_port_sched.md
Name: out_port_sched

Overview:
- Write scheduler and pacer in front of the 4-port output register bank.
- The CPU posts output-port writes (port select + data) into a small FIFO, then continues without stalling unless the FIFO is full.
- The block drains entries in order to the output bank as single-cycle write-enable pulses.
- Successive pulses are separated by a programmable minimum gap, so external devices see each port value held stable.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- WIDTH, 8, data width; matches the output-bank data width.
- HOLD, 2, number of idle cycles forced after each drain pulse; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  CPU write request, sampled at clk rise.
- wr_port  in  2  target output port, 0..3.
- wr_data  in  WIDTH  data to write to the port.
- wr_full  out  1  FIFO full; a wr_req in this cycle is dropped.
- out_we  out  1  write enable to the output bank; one-cycle pulse.
- out_sel  out  2  port select to the output bank.
- out_data  out  WIDTH  data to the output bank.
- busy  out  1  high when the FIFO is non-empty or state is not IDLE.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and level cleared to 0.
  - State set to IDLE; gap counter set to 0.
  - out_we, out_sel, out_data, wr_full and busy all 0.
  - A reset asserted mid-operation discards all queued entries and any pulse in progress, immediately and without waiting for clk.
- Push: at a clk rise, if wr_req=1 and wr_full=0, {wr_port, wr_data} is written at the tail and the tail pointer increments modulo DEPTH.
- Dropped push: if wr_req=1 while wr_full=1, the write is discarded and no state changes.
- wr_full is derived from the registered level (level==DEPTH). A pop in the same cycle does not free a slot for that cycle's push.
- All outputs are registered.
- FSM states: IDLE, GAP.
  - IDLE, level>0 at a clk rise:
    - out_we<=1; out_sel/out_data <= head entry; head pops.
    - gap counter <= HOLD; state -> GAP.
  - IDLE, level==0: out_we<=0; stay in IDLE.
  - GAP: out_we<=0 on the first edge; counter decrements once per clk. When the counter reaches 1 at a rising edge, state -> IDLE.
  - Result: exactly HOLD low cycles between consecutive out_we pulses.
- out_sel/out_data hold their last issued value after the pulse until the next issue.
- Latency: a write accepted at edge k with the FIFO empty and state IDLE gives out_we high for the cycle following edge k+1.
- Simultaneous push and pop: level unchanged; ordering stays strictly FIFO.
- Pointer wrap-around at DEPTH is silent; level tracks occupancy exactly (0..DEPTH).
- Writes to the same port are never merged; every accepted write produces exactly one out_we pulse.

Optional Feature:
- Macro: OUT_SCHED_OVF_EN.
- Defined:
  - Adds input ovf_clr (1) and output ovf (1).
  - ovf is set at the clk rise where a push is dropped (wr_req=1 and wr_full=1).
  - ovf stays set until ovf_clr=1 at a clk rise or reset. If a set and a clear occur in the same cycle, set wins.
  - ovf resets to 0.
- Not defined: neither port exists; dropped writes leave no trace.

Test Plan:
1. DEPTH=4, HOLD=2: single wr_req with wr_port=2, wr_data=0x5A accepted at edge 1 -> out_we=1 only in the cycle after edge 2, with out_sel=2 and out_data=0x5A; level returns to 0; busy low after the gap ends.
2. HOLD=2: four back-to-back writes (p0=0x11, p1=0x22, p3=0x33, p0=0x44) -> four out_we pulses in that order, each followed by exactly 2 low cycles; wr_full never asserted.
3. HOLD=8: six consecutive writes A–F -> wr_full=1 after edge 5 with level=4, F dropped, A–E drained in order; with OUT_SCHED_OVF_EN defined, ovf=1 until ovf_clr pulses.
4. Full FIFO with a pop at the same edge as wr_req=1 -> push rejected, level becomes 3, and the next-cycle push is accepted.
5. reset driven low mid-GAP with 3 entries queued -> out_we, level and busy are 0 immediately without a clk edge; after release, no out_we pulse occurs until a new write.
6. Wrap test: 10 writes interleaved with drains over the pointer wrap -> all 10 values appear on out_data in order with correct out_sel.
